cache_req_sequencer: RTL and testbench

- Front-end controller for the per-line MESI state logic in the L2 cache model.
- Arbitrates between the processor-side (L1) request stream and the snoop request stream, then fetches the stored line state from the tag/state array.
- Sequences the MESI logic through a load -> execute -> capture cycle and writes the updated state back. Returns a per-request response to the requester.

---
 rtl/cache_req_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cache_req_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_sequencer.sv
// Front-end sequencer for the per-line MESI logic. It arbitrates L1 against snoop requests, looks up the
// stored line state, runs MESI load/execute/capture and writes the result back. CACHE_SEQ_STATS_EN adds counters.
module cache_req_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              pr_valid,
    output logic              pr_ready,
    input  logic [3:0]        pr_cmd,
    input  logic [ADDR_W-1:0] pr_addr,
    input  logic              sn_valid,
    output logic              sn_ready,
    input  logic [3:0]        sn_cmd,
    input  logic [ADDR_W-1:0] sn_addr,
    input  logic              bus_hit_in,
    output logic              tag_req,
    output logic [ADDR_W-1:0] tag_addr,
    input  logic              tag_ack,
    input  logic              tag_hit,
    input  logic [1:0]        tag_state,
    output logic              tag_wr,
    output logic [1:0]        tag_wr_state,
    output logic              mesi_load,
    output logic [1:0]        mesi_state_o,
    output logic              mesi_cmd_vld,
    output logic [3:0]        mesi_nmsg,
    output logic              mesi_c,
    input  logic [1:0]        mesi_state_i,
    output logic              rsp_valid,
    output logic              rsp_src,
    output logic [1:0]        rsp_state,
    output logic              rsp_err,
    output logic [2:0]        dbg_state
`ifdef CACHE_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_hits,
    output logic [CNT_W-1:0]  stat_misses,
    output logic [CNT_W-1:0]  stat_snoops,
    output logic [CNT_W-1:0]  stat_errs
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_LOAD, S_EXEC, S_CAPT, S_WB, S_RSP
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q;
    logic [3:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              src_q, err_q, c_q;
    logic [1:0]        ld_state_q, new_q;
    logic              starved, sn_grant, pr_grant, grant_err;

    // Handshake: valid is held by the requester until ready; ready pulses for one cycle in IDLE and
    // cmd/addr are captured on that same clock edge.
    assign starved   = (starve_q == SW'(STARVE_MAX));
    assign sn_grant  = (state_q == S_IDLE) && sn_valid && !(pr_valid && starved);
    assign pr_grant  = (state_q == S_IDLE) && pr_valid && !sn_grant;
    assign grant_err = sn_grant ? !((sn_cmd >= 4'd3) && (sn_cmd <= 4'd6)) : (pr_cmd > 4'd2);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (sn_grant || pr_grant) state_d = grant_err ? S_RSP : S_LOOKUP;
            S_LOOKUP: if (tag_ack) state_d = S_LOAD;
            S_LOAD:   state_d = S_EXEC;
            S_EXEC:   state_d = S_CAPT;
            S_CAPT:   state_d = S_WB;
            S_WB:     state_d = S_RSP;
            S_RSP:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pr_ready     = 1'b0;
        sn_ready     = 1'b0;
        tag_req      = 1'b0;
        tag_addr     = '0;
        tag_wr       = 1'b0;
        tag_wr_state = 2'd0;
        mesi_load    = 1'b0;
        mesi_state_o = 2'd0;
        mesi_cmd_vld = 1'b0;
        mesi_nmsg    = 4'hF;
        mesi_c       = c_q;
        rsp_valid    = 1'b0;
        rsp_src      = 1'b0;
        rsp_state    = 2'd0;
        rsp_err      = 1'b0;
        case (state_q)
            S_IDLE: begin
                pr_ready = pr_grant;
                sn_ready = sn_grant;
            end
            S_LOOKUP: begin
                tag_req  = 1'b1;
                tag_addr = addr_q;
            end
            S_LOAD: begin
                mesi_load    = 1'b1;
                mesi_state_o = ld_state_q;
                mesi_c       = bus_hit_in;
            end
            S_EXEC: begin
                mesi_nmsg    = cmd_q;
                mesi_cmd_vld = 1'b1;
            end
            S_WB: begin
                tag_wr       = 1'b1;
                tag_wr_state = new_q;
                tag_addr     = addr_q;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                rsp_src   = src_q;
                rsp_state = err_q ? 2'd0 : new_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    // Request context and the state values travelling through the MESI pipeline.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            starve_q   <= '0;
            cmd_q      <= 4'd0;
            addr_q     <= '0;
            src_q      <= 1'b0;
            err_q      <= 1'b0;
            c_q        <= 1'b0;
            ld_state_q <= 2'd0;
            new_q      <= 2'd0;
        end else begin
            if (!pr_valid || pr_grant) starve_q <= '0;
            else if (sn_grant && !starved) starve_q <= starve_q + 1'b1;
            if (sn_grant || pr_grant) begin
                cmd_q  <= sn_grant ? sn_cmd : pr_cmd;
                addr_q <= sn_grant ? sn_addr : pr_addr;
                src_q  <= sn_grant;
                err_q  <= grant_err;
            end
            if (state_q == S_LOOKUP && tag_ack) ld_state_q <= tag_hit ? tag_state : 2'd0;
            if (state_q == S_LOAD) c_q <= bus_hit_in;
            else if (state_q == S_RSP) c_q <= 1'b0;
            if (state_q == S_CAPT) new_q <= mesi_state_i;
        end
    end

`ifdef CACHE_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_snoops <= '0;
            stat_errs   <= '0;
        end else begin
            if (state_q == S_LOOKUP && tag_ack) begin
                if (tag_hit && !(&stat_hits)) stat_hits <= stat_hits + CNT_W'(1);
                if (!tag_hit && !(&stat_misses)) stat_misses <= stat_misses + CNT_W'(1);
            end
            if (sn_grant && !(&stat_snoops)) stat_snoops <= stat_snoops + CNT_W'(1);
            if ((sn_grant || pr_grant) && grant_err && !(&stat_errs)) stat_errs <= stat_errs + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cache_req_sequencer.sv
// Bench for cache_req_sequencer: a transaction-level timeline model predicts every output each cycle,
// plus directed scenarios with literal latency/state expectations.
module tb_cache_req_sequencer;

    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 16;

    logic              clk = 1'b0;
    logic              rstb = 1'b0;
    logic              pr_valid, sn_valid, bus_hit_in, tag_ack, tag_hit;
    logic [3:0]        pr_cmd, sn_cmd;
    logic [ADDR_W-1:0] pr_addr, sn_addr;
    logic [1:0]        tag_state, mesi_state_i;
    logic              pr_ready, sn_ready, tag_req, tag_wr, mesi_load, mesi_cmd_vld, mesi_c;
    logic              rsp_valid, rsp_src, rsp_err;
    logic [ADDR_W-1:0] tag_addr;
    logic [1:0]        tag_wr_state, mesi_state_o, rsp_state;
    logic [3:0]        mesi_nmsg;
    logic [2:0]        dbg_state;
`ifdef CACHE_SEQ_STATS_EN
    logic [CNT_W-1:0]  stat_hits, stat_misses, stat_snoops, stat_errs;
`endif

    always #5 clk = ~clk;

    cache_req_sequencer #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstb(rstb),
        .pr_valid(pr_valid), .pr_ready(pr_ready), .pr_cmd(pr_cmd), .pr_addr(pr_addr),
        .sn_valid(sn_valid), .sn_ready(sn_ready), .sn_cmd(sn_cmd), .sn_addr(sn_addr),
        .bus_hit_in(bus_hit_in),
        .tag_req(tag_req), .tag_addr(tag_addr), .tag_ack(tag_ack), .tag_hit(tag_hit),
        .tag_state(tag_state), .tag_wr(tag_wr), .tag_wr_state(tag_wr_state),
        .mesi_load(mesi_load), .mesi_state_o(mesi_state_o), .mesi_cmd_vld(mesi_cmd_vld),
        .mesi_nmsg(mesi_nmsg), .mesi_c(mesi_c), .mesi_state_i(mesi_state_i),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_state(rsp_state), .rsp_err(rsp_err),
        .dbg_state(dbg_state)
`ifdef CACHE_SEQ_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses)
        , .stat_snoops(stat_snoops), .stat_errs(stat_errs)
`endif
    );

    int n_checks = 0;
    int n_errs   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Expected outputs for the current cycle
    logic              e_pr_ready, e_sn_ready, e_tag_req, e_tag_wr, e_mesi_load, e_cmd_vld, e_mesi_c;
    logic              e_rsp_valid, e_rsp_src, e_rsp_err;
    logic [ADDR_W-1:0] e_tag_addr;
    logic [1:0]        e_wr_state, e_state_o, e_rsp_state;
    logic [3:0]        e_nmsg;

    // Scoreboard of responses: {src, state, err}
    logic [3:0] exp_q[$];

    // Model state: one request in flight, k = cycles since its grant
    bit                busy, rand_mode, hold_both;
    int                k, starve, cyc, done_cnt;
    bit                pr_pend, sn_pend;
    logic [3:0]        pr_cmd_p, sn_cmd_p;
    logic [ADDR_W-1:0] pr_addr_p, sn_addr_p;
    int                nx_d;
    bit                nx_hit, nx_bus;
    logic [1:0]        nx_tstate, nx_new;
    bit                tx_src, tx_err, tx_hit, tx_bus;
    logic [3:0]        tx_cmd;
    logic [ADDR_W-1:0] tx_addr;
    int                tx_d;
    logic [1:0]        tx_tstate, tx_new;

    // Observations of the DUT, used by the directed literal checks
    int         rdy_cyc, last_lat, treq_cnt, load_cnt, nmsg_cnt, wr_cnt;
    logic [1:0] last_load_state, last_wr_state;
    logic [3:0] last_nmsg, last_rsp, rsp_e;
    bit         dut_grants[$];

    function automatic void set_idle_exp();
        e_pr_ready = 0; e_sn_ready = 0; e_tag_req = 0; e_tag_wr = 0; e_mesi_load = 0;
        e_cmd_vld = 0; e_mesi_c = 0; e_rsp_valid = 0; e_rsp_src = 0; e_rsp_err = 0;
        e_tag_addr = '0; e_wr_state = 0; e_state_o = 0; e_rsp_state = 0; e_nmsg = 4'hF;
    endfunction

    always @(negedge clk) begin
        chk("pr_ready", pr_ready, e_pr_ready);
        chk("sn_ready", sn_ready, e_sn_ready);
        chk("tag_req", tag_req, e_tag_req);
        chk("tag_addr", tag_addr, e_tag_addr);
        chk("tag_wr", tag_wr, e_tag_wr);
        chk("tag_wr_state", tag_wr_state, e_wr_state);
        chk("mesi_load", mesi_load, e_mesi_load);
        chk("mesi_state_o", mesi_state_o, e_state_o);
        chk("mesi_cmd_vld", mesi_cmd_vld, e_cmd_vld);
        chk("mesi_nmsg", mesi_nmsg, e_nmsg);
        chk("mesi_c", mesi_c, e_mesi_c);
        chk("rsp_valid", rsp_valid, e_rsp_valid);
        chk("rsp_src", rsp_src, e_rsp_src);
        chk("rsp_state", rsp_state, e_rsp_state);
        chk("rsp_err", rsp_err, e_rsp_err);
        if (pr_ready) begin rdy_cyc = cyc; dut_grants.push_back(1'b0); end
        if (sn_ready) begin rdy_cyc = cyc; dut_grants.push_back(1'b1); end
        if (tag_req) treq_cnt++;
        if (mesi_load) begin load_cnt++; last_load_state = mesi_state_o; end
        if (mesi_nmsg != 4'hF) begin nmsg_cnt++; last_nmsg = mesi_nmsg; end
        if (tag_wr) begin wr_cnt++; last_wr_state = tag_wr_state; end
        if (rsp_valid) begin
            last_lat = cyc - rdy_cyc;
            last_rsp = {rsp_src, rsp_state, rsp_err};
            if (exp_q.size() == 0) chk("rsp_orphan", rsp_valid, 1'b0);
            else begin
                rsp_e = exp_q.pop_front();
                chk("rsp_word", {rsp_src, rsp_state, rsp_err}, rsp_e);
            end
        end
    end

    task automatic drive_req();
        pr_valid = pr_pend; pr_cmd = pr_cmd_p; pr_addr = pr_addr_p;
        sn_valid = sn_pend; sn_cmd = sn_cmd_p; sn_addr = sn_addr_p;
    endtask

    task automatic step();
        bit sn_win, pr_win;
        @(posedge clk);
        #1;
        cyc++;
        set_idle_exp();
        tag_ack      = 1'($urandom_range(0, 1));
        tag_hit      = 1'($urandom_range(0, 1));
        tag_state    = 2'($urandom_range(0, 3));
        bus_hit_in   = 1'($urandom_range(0, 1));
        mesi_state_i = 2'($urandom_range(0, 3));
        if (!busy) begin
            if (rand_mode) begin
                if (!pr_pend && $urandom_range(0, 2) == 0) begin
                    pr_pend   = 1;
                    pr_cmd_p  = ($urandom_range(0, 7) == 0) ? 4'(3 + $urandom_range(0, 12)) : 4'($urandom_range(0, 2));
                    pr_addr_p = ADDR_W'($urandom());
                end
                if (!sn_pend && $urandom_range(0, 2) == 0) begin
                    int v;
                    sn_pend   = 1;
                    v         = $urandom_range(0, 11);
                    sn_cmd_p  = ($urandom_range(0, 7) == 0) ? 4'((v < 3) ? v : v + 4) : 4'(3 + $urandom_range(0, 3));
                    sn_addr_p = ADDR_W'($urandom());
                end
            end
            drive_req();
            sn_win = sn_pend && !(pr_pend && starve == STARVE_MAX);
            pr_win = pr_pend && !sn_win;
            e_pr_ready = pr_win;
            e_sn_ready = sn_win;
            if (!pr_pend || pr_win) starve = 0;
            else if (sn_win && starve < STARVE_MAX) starve++;
            if (sn_win || pr_win) begin
                if (rand_mode) begin
                    nx_d = $urandom_range(0, 3); nx_hit = 1'($urandom_range(0, 1));
                    nx_tstate = 2'($urandom_range(0, 3)); nx_bus = 1'($urandom_range(0, 1));
                    nx_new = 2'($urandom_range(0, 3));
                end
                tx_src = sn_win;
                tx_cmd = sn_win ? sn_cmd_p : pr_cmd_p;
                tx_addr = sn_win ? sn_addr_p : pr_addr_p;
                tx_err = sn_win ? !(tx_cmd >= 3 && tx_cmd <= 6) : (tx_cmd > 2);
                tx_d = nx_d; tx_hit = nx_hit; tx_tstate = nx_tstate; tx_bus = nx_bus; tx_new = nx_new;
                exp_q.push_back({tx_src, tx_err ? 2'b00 : tx_new, tx_err});
                busy = 1;
                k = 0;
                if (!hold_both) begin
                    if (sn_win) sn_pend = 0;
                    else pr_pend = 0;
                end
            end
        end else begin
            drive_req();
            if (!pr_pend) starve = 0;
            k++;
            if (tx_err || k == tx_d + 6) begin
                e_rsp_valid = 1; e_rsp_src = tx_src; e_rsp_err = tx_err;
                e_rsp_state = tx_err ? 2'd0 : tx_new;
                e_mesi_c = tx_err ? 1'b0 : tx_bus;
                busy = 0;
                done_cnt++;
            end else if (k <= tx_d + 1) begin
                e_tag_req = 1; e_tag_addr = tx_addr;
                tag_ack = (k == tx_d + 1);
                if (k == tx_d + 1) begin tag_hit = tx_hit; tag_state = tx_tstate; end
            end else if (k == tx_d + 2) begin
                e_mesi_load = 1; e_state_o = tx_hit ? tx_tstate : 2'd0;
                bus_hit_in = tx_bus; e_mesi_c = tx_bus;
            end else if (k == tx_d + 3) begin
                e_nmsg = tx_cmd; e_cmd_vld = 1; e_mesi_c = tx_bus;
            end else if (k == tx_d + 4) begin
                mesi_state_i = tx_new; e_mesi_c = tx_bus;
            end else begin
                e_tag_wr = 1; e_wr_state = tx_new; e_tag_addr = tx_addr; e_mesi_c = tx_bus;
            end
        end
    endtask

    task automatic run_done(input int n, input int budget);
        int target, b;
        target = done_cnt + n;
        b = 0;
        while (done_cnt < target && b < budget) begin step(); b++; end
        if (done_cnt < target) chk("run_timeout", 32'(done_cnt), 32'(target));
        @(negedge clk);
        #1;
    endtask

    task automatic set_tx(input int d, input bit hit, input logic [1:0] ts, input bit bus, input logic [1:0] nw);
        nx_d = d; nx_hit = hit; nx_tstate = ts; nx_bus = bus; nx_new = nw;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int b, base_req, base_load, base_wr, base_nmsg, gbase;
        logic [9:0] pat;
        pr_pend = 0; sn_pend = 0; pr_cmd_p = 0; sn_cmd_p = 0; pr_addr_p = '0; sn_addr_p = '0;
        busy = 0; rand_mode = 0; hold_both = 0; starve = 0; cyc = 0; done_cnt = 0; k = 0;
        drive_req();
        bus_hit_in = 0; tag_ack = 0; tag_hit = 0; tag_state = 0; mesi_state_i = 0;
        set_idle_exp();
        @(negedge clk);
        #1;
        chk("reset_nmsg", mesi_nmsg, 4'hF);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        rstb = 1;

        // Processor RD_D, miss, MESI returns E
        pr_pend = 1; pr_cmd_p = 4'd0; pr_addr_p = 32'h0000_1000;
        set_tx(0, 0, 2'd3, 0, 2'd2);
        run_done(1, 30);
        chk("rdd_latency", 32'(last_lat), 6);
        chk("rdd_rsp", last_rsp, 4'b0100);
        chk("rdd_wr_state", last_wr_state, 2'd2);
        chk("rdd_load_state", last_load_state, 2'd0);

        // Snoop RD hitting M, MESI returns S
        base_nmsg = nmsg_cnt;
        sn_pend = 1; sn_cmd_p = 4'd4; sn_addr_p = 32'hABCD_0040;
        set_tx(0, 1, 2'd3, 1, 2'd1);
        run_done(1, 30);
        chk("snrd_load_state", last_load_state, 2'd3);
        chk("snrd_nmsg_cycles", 32'(nmsg_cnt - base_nmsg), 1);
        chk("snrd_nmsg", last_nmsg, 4'd4);
        chk("snrd_wr_state", last_wr_state, 2'd1);
        chk("snrd_rsp", last_rsp, 4'b1010);

        // Illegal processor command
        base_req = treq_cnt; base_load = load_cnt; base_wr = wr_cnt;
        pr_pend = 1; pr_cmd_p = 4'd5; pr_addr_p = 32'h0000_2000;
        run_done(1, 30);
        chk("ill_latency", 32'(last_lat), 1);
        chk("ill_rsp", last_rsp, 4'b0001);
        chk("ill_no_tag_req", 32'(treq_cnt - base_req), 0);
        chk("ill_no_load", 32'(load_cnt - base_load), 0);
        chk("ill_no_wr", 32'(wr_cnt - base_wr), 0);

        // tag_ack three cycles late
        base_req = treq_cnt;
        pr_pend = 1; pr_cmd_p = 4'd2; pr_addr_p = 32'h0000_3000;
        set_tx(3, 1, 2'd1, 0, 2'd1);
        run_done(1, 40);
        chk("slow_latency", 32'(last_lat), 9);
        chk("slow_tag_req_cycles", 32'(treq_cnt - base_req), 4);

        // Both requesters held high: starvation guard
        gbase = dut_grants.size();
        hold_both = 1;
        pr_pend = 1; pr_cmd_p = 4'd0; pr_addr_p = 32'h0000_4000;
        sn_pend = 1; sn_cmd_p = 4'd4; sn_addr_p = 32'h0000_5000;
        set_tx(0, 0, 2'd0, 0, 2'd2);
        run_done(10, 200);
        hold_both = 0; pr_pend = 0; sn_pend = 0;
        pat = 10'b1111011110;
        chk("starve_grant_count", 32'(dut_grants.size() - gbase), 10);
        for (int i = 0; i < 10; i++) begin
            if (gbase + i < dut_grants.size())
                chk($sformatf("starve_grant_%0d", i), dut_grants[gbase + i], pat[9 - i]);
        end

        // Reset asserted during EXEC
        pr_pend = 1; pr_cmd_p = 4'd1; pr_addr_p = 32'h0000_6000;
        set_tx(0, 1, 2'd2, 0, 2'd3);
        b = 0;
        while (!(busy && k == tx_d + 3) && b < 20) begin step(); b++; end
        base_wr = wr_cnt;
        #1;
        rstb = 0;
        pr_pend = 0; sn_pend = 0; busy = 0; starve = 0;
        drive_req();
        exp_q.delete();
        set_idle_exp();
        @(negedge clk);
        #1;
        chk("rst_nmsg", mesi_nmsg, 4'hF);
        chk("rst_cmd_vld", mesi_cmd_vld, 1'b0);
        rstb = 1;
        for (int i = 0; i < 8; i++) step();
        chk("rst_no_wb", 32'(wr_cnt - base_wr), 0);
        pr_pend = 1; pr_cmd_p = 4'd2; pr_addr_p = 32'h0000_7000;
        set_tx(0, 1, 2'd1, 1, 2'd1);
        run_done(1, 30);
        chk("post_rst_latency", 32'(last_lat), 6);
        chk("post_rst_rsp", last_rsp, 4'b0010);

        // Random traffic, then drain
        rand_mode = 1;
        for (int i = 0; i < 2000; i++) step();
        rand_mode = 0;
        b = 0;
        while ((busy || pr_pend || sn_pend) && b < 200) begin step(); b++; end
        for (int i = 0; i < 2; i++) step();
        @(negedge clk);
        #1;
        chk("drain_idle", 32'(busy || pr_pend || sn_pend), 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
